// File: rtl/student_block.sv
// Per-pixel video stream processor: bypass, binarize, invert or horizontal gradient,
// selected per field, with one registered output strobe per accepted pixel.
module student_block #(
  parameter logic [7:0] THRESHOLD = 8'd128,
  parameter int         DATA_W    = 8,
  parameter int         ADDR_W    = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        mode,
  input  logic              video_frame_valid,
  input  logic              video_line_valid,
  input  logic              video_data_valid,
  input  logic [DATA_W-1:0] video_data_in,
  input  logic [ADDR_W-1:0] video_address,
  output logic              video_data_ready,
  output logic [DATA_W-1:0] video_data_out
);

  typedef enum logic [1:0] {
    MODE_BYPASS   = 2'b00,
    MODE_BINARIZE = 2'b01,
    MODE_INVERT   = 2'b10,
    MODE_GRADIENT = 2'b11
  } mode_t;

  // Handshake: a pixel is taken on any rising edge where data_valid, line_valid and
  // frame_valid are all high; video_data_ready is high for exactly the following
  // cycle with video_data_out valid. There is no backpressure and no buffering.

  logic              frame_valid_q;
  mode_t             mode_r;
  logic [DATA_W-1:0] prev_pixel;

  logic              frame_rise;
  logic              acc;
  logic              line_start;
  mode_t             mode_eff;
  logic [DATA_W-1:0] q_eff;
  logic [DATA_W:0]   diff;
  logic [DATA_W-1:0] grad;
  logic [DATA_W-1:0] result;

  assign frame_rise = video_frame_valid & ~frame_valid_q;
  assign acc        = video_data_valid & video_line_valid & video_frame_valid;
  assign line_start = (video_address[9:0] == 10'd0);

  // A pixel arriving on the very edge where the field opens already uses the new mode.
  assign mode_eff = frame_rise ? mode_t'(mode) : mode_r;

  assign q_eff = line_start ? video_data_in : prev_pixel;
  assign diff  = {1'b0, video_data_in} - {1'b0, q_eff};
  assign grad  = diff[DATA_W] ? DATA_W'(-diff) : diff[DATA_W-1:0];

  always_comb begin
    result = video_data_in;
    unique case (mode_eff)
      MODE_BYPASS:   result = video_data_in;
      MODE_BINARIZE: result = (video_data_in >= THRESHOLD) ? {DATA_W{1'b1}} : {DATA_W{1'b0}};
      MODE_INVERT:   result = {DATA_W{1'b1}} - video_data_in;
      MODE_GRADIENT: result = grad;
      default:       result = video_data_in;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_valid_q <= 1'b0;
      mode_r        <= MODE_BINARIZE;
    end else begin
      frame_valid_q <= video_frame_valid;
      if (frame_rise) begin
        mode_r <= mode_t'(mode);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_pixel       <= '0;
      video_data_ready <= 1'b0;
      video_data_out   <= '0;
    end else begin
      video_data_ready <= acc;
      if (acc) begin
        prev_pixel     <= video_data_in;
        video_data_out <= result;
      end
    end
  end

endmodule

// File: tb/tb_student_block.sv
// Directed bench for student_block: each mode, gating, mode latching, async reset
// mid-line and a reduced full-stream pulse count.
module tb_student_block;

  logic        clk;
  logic        rst_n;
  logic [1:0]  mode;
  logic        video_frame_valid;
  logic        video_line_valid;
  logic        video_data_valid;
  logic [7:0]  video_data_in;
  logic [19:0] video_address;
  logic        video_data_ready;
  logic [7:0]  video_data_out;

  int n_checks = 0;
  int n_errors = 0;
  int pulse_cnt = 0;
  logic count_en = 1'b0;

  student_block dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .mode              (mode),
    .video_frame_valid (video_frame_valid),
    .video_line_valid  (video_line_valid),
    .video_data_valid  (video_data_valid),
    .video_data_in     (video_data_in),
    .video_address     (video_address),
    .video_data_ready  (video_data_ready),
    .video_data_out    (video_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (count_en && video_data_ready) pulse_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_field(input logic [1:0] m, input logic fld);
    @(negedge clk);
    video_frame_valid = 1'b0;
    video_line_valid  = 1'b0;
    mode = m;
    @(negedge clk);
    video_frame_valid = 1'b1;
    @(negedge clk);
    video_line_valid = 1'b1;
    video_address = {9'd0, fld, 10'd0};
  endtask

  task automatic new_line(input logic [8:0] row, input logic fld);
    @(negedge clk);
    video_line_valid = 1'b0;
    @(negedge clk);
    video_line_valid = 1'b1;
    video_address = {row, fld, 10'd0};
  endtask

  // Accept one pixel, then check the ready pulse, its data and that it lasts one cycle.
  task automatic send_pix(input string tag, input logic [7:0] p, input logic [9:0] col,
                          input logic [7:0] exp);
    @(negedge clk);
    video_data_valid = 1'b1;
    video_data_in    = p;
    video_address[9:0] = col;
    @(posedge clk);
    #1;
    check({tag, "_rdy"}, video_data_ready, 1);
    check({tag, "_out"}, video_data_out, exp);
    @(negedge clk);
    video_data_valid = 1'b0;
    @(posedge clk);
    #1;
    check({tag, "_rdy_low"}, video_data_ready, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    mode = 2'b00;
    video_frame_valid = 1'b0;
    video_line_valid  = 1'b0;
    video_data_valid  = 1'b0;
    video_data_in     = 8'h00;
    video_address     = '0;
    #23;
    check("reset_rdy", video_data_ready, 0);
    check("reset_out", video_data_out, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Bypass
    start_field(2'b00, 1'b0);
    send_pix("byp0", 8'h10, 10'd0, 8'h10);
    send_pix("byp1", 8'h80, 10'd1, 8'h80);
    send_pix("byp2", 8'hFF, 10'd2, 8'hFF);

    // Threshold
    start_field(2'b01, 1'b1);
    send_pix("thr0", 8'h7F, 10'd0, 8'h00);
    send_pix("thr1", 8'h80, 10'd1, 8'hFF);
    send_pix("thr2", 8'h00, 10'd2, 8'h00);
    send_pix("thr3", 8'hFE, 10'd3, 8'hFF);

    // Invert plus gating
    start_field(2'b10, 1'b0);
    send_pix("inv0", 8'h3C, 10'd0, 8'hC3);
    @(negedge clk);
    video_line_valid = 1'b0;
    video_data_valid = 1'b1;
    video_data_in    = 8'h55;
    video_address[9:0] = 10'd1;
    @(posedge clk);
    #1;
    check("gate_rdy", video_data_ready, 0);
    check("gate_out", video_data_out, 8'hC3);
    @(negedge clk);
    video_data_valid = 1'b0;
    @(posedge clk);
    #1;
    check("gate_rdy2", video_data_ready, 0);

    // Gradient
    start_field(2'b11, 1'b1);
    send_pix("grd0", 8'h50, 10'd0, 8'h00);
    send_pix("grd1", 8'h20, 10'd1, 8'h30);
    send_pix("grd2", 8'h90, 10'd2, 8'h70);
    send_pix("grd3", 8'h90, 10'd3, 8'h00);
    new_line(9'd1, 1'b1);
    send_pix("grd_l2c0", 8'hFF, 10'd0, 8'h00);
    send_pix("grd_l2c1", 8'h0F, 10'd1, 8'hF0);

    // Mode latching
    start_field(2'b01, 1'b0);
    send_pix("lat0", 8'h90, 10'd0, 8'hFF);
    mode = 2'b00;
    send_pix("lat1", 8'h10, 10'd1, 8'h00);
    send_pix("lat2", 8'h90, 10'd2, 8'hFF);
    start_field(2'b00, 1'b1);
    send_pix("lat_nxt", 8'h90, 10'd0, 8'h90);

    // Async reset mid-line in gradient mode
    start_field(2'b11, 1'b0);
    send_pix("rst_pre0", 8'h20, 10'd0, 8'h00);
    @(negedge clk);
    video_data_valid = 1'b1;
    video_data_in    = 8'hA0;
    video_address[9:0] = 10'd1;
    @(posedge clk);
    #1;
    check("rst_pre_rdy", video_data_ready, 1);
    check("rst_pre_out", video_data_out, 8'h80);
    video_data_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_async_rdy", video_data_ready, 0);
    check("rst_async_out", video_data_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_post_rdy", video_data_ready, 0);
    // frame_valid is still high, so the released delay flop recaptures mode 11.
    send_pix("rst_q0", 8'h40, 10'd5, 8'h40);

    // Reduced full stream: 2 frames x 2 fields x 3 lines x 5 pixels, 8-clock pitch
    @(negedge clk);
    pulse_cnt = 0;
    count_en  = 1'b1;
    for (int f = 0; f < 4; f++) begin
      start_field(2'b00, f[0]);
      for (int r = 0; r < 3; r++) begin
        if (r != 0) new_line(r[8:0], f[0]);
        for (int c = 0; c < 5; c++) begin
          @(negedge clk);
          video_data_valid = 1'b1;
          video_data_in    = 8'($urandom_range(0, 255));
          video_address[9:0] = c[9:0];
          @(negedge clk);
          video_data_valid = 1'b0;
          repeat (6) @(negedge clk);
        end
      end
    end
    repeat (3) @(negedge clk);
    count_en = 1'b0;
    check("stream_pulses", pulse_cnt, 60);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
